// File: rtl/alu_decoder_pipe.sv
// rtl/alu_decoder_pipe.sv - ALU control decoder with 2-entry output FIFO; ALU_DECODER_PIPE_MEXT_EN enables M-extension decode
module alu_decoder_pipe #(
    parameter int CTRL_W = 4,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [6:0]        op,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              illegal,
    output logic [TAG_W-1:0]  tag_out,
    output logic [15:0]       illegal_cnt
);

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
`ifdef ALU_DECODER_PIPE_MEXT_EN
    localparam logic [3:0] ALU_MUL   = 4'b1011;
    localparam logic [3:0] ALU_MULH  = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_REM   = 4'b1110;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t state, next_state;

    logic             r_type;
    logic             f7_zero;
    logic             f7_alt;
    logic             mext_hit;
    logic             arith_bad;
    logic [3:0]       dec_ctrl;
    logic             dec_ill;
    logic             push;
    logic             pop;
    logic             load_head_in;
    logic             load_head_tail;
    logic             load_tail;
    logic [3:0]       head_ctrl;
    logic             head_ill;
    logic [TAG_W-1:0] head_tag;
    logic [3:0]       tail_ctrl;
    logic             tail_ill;
    logic [TAG_W-1:0] tail_tag;
    logic [15:0]      cnt;
    logic             unused_op;

    // Only op[5] distinguishes R-type from I-type; the rest of the opcode is ignored.
    assign unused_op = ^{op[6], op[4:0]};
    assign r_type    = op[5];
    assign f7_zero   = (funct7 == 7'b0000000);
    assign f7_alt    = (funct7 == 7'b0100000);

`ifdef ALU_DECODER_PIPE_MEXT_EN
    assign mext_hit = r_type && (funct7 == 7'b0000001);
`else
    assign mext_hit = 1'b0;
`endif

    // Encodings that are not valid base-ISA arithmetic; an M-extension hit is decoded before this is consulted.
    assign arith_bad = (r_type && !(f7_zero || f7_alt))
                     || (r_type && f7_alt && !((funct3 == 3'b000) || (funct3 == 3'b101)))
                     || (!r_type && (funct3 == 3'b001) && !f7_zero)
                     || (!r_type && (funct3 == 3'b101) && !(f7_zero || f7_alt));

    // Combinational decode of the presented request; illegal encodings fall back to ADD.
    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_ill  = 1'b0;
        case (ALUOp)
            2'b00: dec_ctrl = ALU_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec_ctrl = ALU_SLTU;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            2'b10: begin
                if (mext_hit) begin
`ifdef ALU_DECODER_PIPE_MEXT_EN
                    case (funct3)
                        3'b000:                 dec_ctrl = ALU_MUL;
                        3'b001, 3'b010, 3'b011: dec_ctrl = ALU_MULH;
                        3'b100, 3'b101:         dec_ctrl = ALU_DIV;
                        default:                dec_ctrl = ALU_REM;
                    endcase
`endif
                end else if (arith_bad) begin
                    dec_ill = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec_ctrl = (r_type && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b010:  dec_ctrl = ALU_SLT;
                        3'b011:  dec_ctrl = ALU_SLTU;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  dec_ctrl = ALU_OR;
                        default: dec_ctrl = ALU_AND;
                    endcase
                end
            end
            default: dec_ctrl = ALU_PASSB;
        endcase
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state == ONE) || (state == FULL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // FIFO occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next occupancy and which storage slot loads; head is always the presented entry.
    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    next_state = FULL;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state     = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Head/tail storage; head only changes on a load so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ctrl <= 4'b0000;
            head_ill  <= 1'b0;
            head_tag  <= '0;
            tail_ctrl <= 4'b0000;
            tail_ill  <= 1'b0;
            tail_tag  <= '0;
        end else begin
            if (load_head_in) begin
                head_ctrl <= dec_ctrl;
                head_ill  <= dec_ill;
                head_tag  <= tag_in;
            end else if (load_head_tail) begin
                head_ctrl <= tail_ctrl;
                head_ill  <= tail_ill;
                head_tag  <= tail_tag;
            end
            if (load_tail) begin
                tail_ctrl <= dec_ctrl;
                tail_ill  <= dec_ill;
                tail_tag  <= tag_in;
            end
        end
    end

    // Saturating count of accepted illegal decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 16'h0000;
        end else if (push && dec_ill && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'h0001;
        end
    end

    assign illegal_cnt = cnt;

    // Result fields are forced to zero whenever nothing is presented.
    always_comb begin
        ALUControl = '0;
        illegal    = 1'b0;
        tag_out    = '0;
        if (out_valid) begin
            ALUControl = CTRL_W'(head_ctrl);
            illegal    = head_ill;
            tag_out    = head_tag;
        end
    end

endmodule

// File: tb/tb_alu_decoder_pipe.sv
// tb/tb_alu_decoder_pipe.sv - scoreboard testbench for alu_decoder_pipe
module tb_alu_decoder_pipe;
    localparam int CTRL_W = 4;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        ALUOp = 2'b00;
    logic [2:0]        funct3 = 3'b000;
    logic [6:0]        funct7 = 7'b0000000;
    logic [6:0]        op = 7'b0000000;
    logic [TAG_W-1:0]  tag_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] ALUControl;
    logic              illegal;
    logic [TAG_W-1:0]  tag_out;
    logic [15:0]       illegal_cnt;

    typedef struct packed {
        logic [3:0]       ctrl;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] exp_cnt = 16'h0000;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_decoder_pipe #(.CTRL_W(CTRL_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .ALUControl(ALUControl),
        .illegal(illegal), .tag_out(tag_out), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // Reference decode, returns {illegal, code}.
    function automatic logic [4:0] model(input logic [1:0] a, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic o5);
        logic [4:0] r;
        r = 5'h10;
        if (a == 2'b00) return 5'h00;
        if (a == 2'b11) return 5'h0A;
        if (a == 2'b01) begin
            if (f3 == 3'd2 || f3 == 3'd3) return 5'h10;
            if (f3 <= 3'd1) return 5'h01;
            if (f3 <= 3'd5) return 5'h05;
            return 5'h06;
        end
        if (o5 && f7 == 7'h01) begin
`ifdef ALU_DECODER_PIPE_MEXT_EN
            if (f3 == 3'd0) return 5'h0B;
            if (f3 <= 3'd3) return 5'h0C;
            if (f3 <= 3'd5) return 5'h0D;
            return 5'h0E;
`else
            return 5'h10;
`endif
        end
        if (o5) begin
            if (f7 != 7'h00 && f7 != 7'h20) return 5'h10;
            if (f7 == 7'h20) begin
                if (f3 == 3'd0) return 5'h01;
                if (f3 == 3'd5) return 5'h09;
                return 5'h10;
            end
        end else begin
            if (f3 == 3'd1 && f7 != 7'h00) return 5'h10;
            if (f3 == 3'd5 && f7 == 7'h20) return 5'h09;
            if (f3 == 3'd5 && f7 != 7'h00) return 5'h10;
        end
        case (f3)
            3'd0: r = 5'h00;
            3'd1: r = 5'h07;
            3'd2: r = 5'h05;
            3'd3: r = 5'h06;
            3'd4: r = 5'h04;
            3'd5: r = 5'h08;
            3'd6: r = 5'h03;
            default: r = 5'h02;
        endcase
        return r;
    endfunction

    // Called at a falling edge: logs the handshakes the next rising edge will perform, then crosses it.
    task automatic edge_step();
        logic [4:0] m;
        exp_t       e;
        if (in_valid && in_ready) begin
            m      = model(ALUOp, funct3, funct7, op[5]);
            e.ctrl = m[3:0];
            e.ill  = m[4];
            e.tag  = tag_in;
            sbq.push_back(e);
            if (m[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [6:0] o, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        ALUOp    = a;
        funct3   = f3;
        funct7   = f7;
        op       = o;
        tag_in   = t;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, illegal, ALUControl, tag_out, illegal_cnt} !==
            {1'b0, 1'b1, 1'b0, {CTRL_W{1'b0}}, {TAG_W{1'b0}}, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b ready=%b ill=%b ctrl=%h tag=%0d cnt=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, illegal, ALUControl, tag_out, illegal_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_first_push();
        drive(2'b10, 3'b000, 7'b0100000, 7'b0110011, 5'd3);
        out_ready = 1'b1;
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || ALUControl !== 4'b0001 || tag_out !== 5'd3 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL first_push: valid=%b ctrl=%b tag=%0d ill=%b, required 1 0001 3 0",
                     out_valid, ALUControl, tag_out, illegal);
        end
        edge_step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(2'b10, 3'b111, 7'b0000000, 7'b0110011, 5'd7);
        @(negedge clk);
        edge_step();
        drive(2'b10, 3'b101, 7'b0100000, 7'b0010011, 5'd9);
        @(negedge clk);
        n_cmp++;
        if (sbq.size() == 0 || out_valid !== 1'b1 || ALUControl !== sbq[0].ctrl || tag_out !== sbq[0].tag) begin
            n_bad++;
            $display("FAIL b2b_first_out: valid=%b ctrl=%b tag=%0d, required 1 0010 7", out_valid, ALUControl, tag_out);
        end
        edge_step();
        drive(2'b01, 3'b011, 7'b0000000, 7'b0110011, 5'd12);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_in_ready[%0d]: got %b, required 0", i, in_ready);
            end
            n_cmp++;
            if (ALUControl !== 4'b0010 || tag_out !== 5'd7 || illegal !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_stable[%0d]: ctrl=%b tag=%0d ill=%b, required 0010 7 0", i, ALUControl, tag_out, illegal);
            end
            edge_step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || ALUControl !== 4'b0010 || tag_out !== 5'd7) begin
            n_bad++;
            $display("FAIL drain_first: valid=%b ctrl=%b tag=%0d, required 1 0010 7", out_valid, ALUControl, tag_out);
        end
        edge_step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || ALUControl !== 4'b1001 || tag_out !== 5'd9) begin
            n_bad++;
            $display("FAIL drain_second: ready=%b valid=%b ctrl=%b tag=%0d, required 1 1 1001 9",
                     in_ready, out_valid, ALUControl, tag_out);
        end
        edge_step();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUControl !== 4'b0000 || tag_out !== 5'd0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: valid=%b ready=%b ctrl=%b tag=%0d ill=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, ALUControl, tag_out, illegal);
        end
        n_cmp++;
        if (illegal_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL held_off_not_counted: cnt=%0d, required 0", illegal_cnt);
        end
        edge_step();
    endtask

    task automatic test_illegal();
        drive(2'b10, 3'b001, 7'b0100000, 7'b0010011, 5'd4);
        out_ready = 1'b1;
        @(negedge clk);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (illegal !== 1'b1 || ALUControl !== 4'b0000 || illegal_cnt !== 16'd1 || tag_out !== 5'd4) begin
            n_bad++;
            $display("FAIL illegal_slli: ill=%b ctrl=%b cnt=%0d tag=%0d, required 1 0000 1 4",
                     illegal, ALUControl, illegal_cnt, tag_out);
        end
        edge_step();
    endtask

    task automatic test_mext();
        drive(2'b10, 3'b100, 7'b0000001, 7'b0110011, 5'd17);
        out_ready = 1'b1;
        @(negedge clk);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
`ifdef ALU_DECODER_PIPE_MEXT_EN
        if (ALUControl !== 4'b1101 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL mext_div: ctrl=%b ill=%b, required 1101 0", ALUControl, illegal);
        end
`else
        if (ALUControl !== 4'b0000 || illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL mext_div_disabled: ctrl=%b ill=%b, required 0000 1", ALUControl, illegal);
        end
`endif
        n_cmp++;
        if (illegal_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL mext_cnt: cnt=%0d, required %0d", illegal_cnt, exp_cnt);
        end
        edge_step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ALUOp     = 2'($urandom);
            funct3    = 3'($urandom);
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            op     = 7'($urandom);
            tag_in = TAG_W'($urandom);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== (sbq.size() != 0) || in_ready !== (sbq.size() < 2)) begin
                n_bad++;
                $display("FAIL rand_flags[%0d]: valid=%b ready=%b, required occupancy %0d", i, out_valid, in_ready, sbq.size());
            end
            n_cmp++;
            if (sbq.size() != 0) begin
                if (ALUControl !== sbq[0].ctrl || illegal !== sbq[0].ill || tag_out !== sbq[0].tag) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: ctrl=%b ill=%b tag=%0d, required %b %b %0d",
                             i, ALUControl, illegal, tag_out, sbq[0].ctrl, sbq[0].ill, sbq[0].tag);
                end
            end else if (ALUControl !== 4'b0000 || illegal !== 1'b0 || tag_out !== 5'd0) begin
                n_bad++;
                $display("FAIL rand_idle_zero[%0d]: ctrl=%b ill=%b tag=%0d, required 0 0 0", i, ALUControl, illegal, tag_out);
            end
            n_cmp++;
            if (illegal_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: cnt=%0d, required %0d", i, illegal_cnt, exp_cnt);
            end
            edge_step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            edge_step();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(2'b01, 3'b010, 7'b0000000, 7'b0110011, 5'd1);
        @(negedge clk);
        edge_step();
        @(negedge clk);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || illegal_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL pre_reset_full: ready=%b valid=%b cnt=%0d, required 0 1 %0d", in_ready, out_valid, illegal_cnt, exp_cnt);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 16'd0 ||
            ALUControl !== 4'b0000 || illegal !== 1'b0 || tag_out !== 5'd0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b ready=%b cnt=%0d ctrl=%b ill=%b tag=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, illegal_cnt, ALUControl, illegal, tag_out);
        end
        sbq.delete();
        exp_cnt = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 3'b000, 7'b0000000, 7'b0110111, 5'd21);
        out_ready = 1'b1;
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || ALUControl !== 4'b1010 || tag_out !== 5'd21 || illegal_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL post_reset_push: valid=%b ctrl=%b tag=%0d cnt=%0d, required 1 1010 21 0",
                     out_valid, ALUControl, tag_out, illegal_cnt);
        end
        edge_step();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_discard: valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_back_to_back();
        test_drain();
        test_illegal();
        test_mext();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
